pl_ex_rns_mcu: RTL
==================

// Module: pl_ex_rns_mcu
// PURPOSE
//   Multi-cycle RNS execute unit. Sits beside the single-cycle ALUs in the EX stage and runs modular
//   multiply, multiply-accumulate and square on all NUM_DOMAINS residue channels in parallel.
//   Each channel uses an MSB-first shift-add modular multiplier. busy stalls IF/ID/EX upstream.
//   Results are handed to the EX pipeline register with a one-cycle done pulse and a destination tag.
// PARAMETERS
//   NUM_DOMAINS  2                      number of residue channels
//   DATA_WID     8                      residue width per channel
//   MODULI       {9'd256,9'd129}        per-channel modulus; channel i = MODULI[i*(DATA_WID+1) +: DATA_WID+1]
//                                       each requires 2^(DATA_WID-1) < m <= 2^DATA_WID
//   DEST_WID     4                      destination tag width {RNS_file, addr[2:0]}
// PORTS
//   clk          in   1                 rising-edge clock
//   reset        in   1                 synchronous, active-high
//   start        in   1                 request; accepted only when ready=1
//   mode         in   2                 00 MUL, 01 MAC, 10 SQR (op1*op1), 11 CLRACC
//   op1, op2     in   NUM_DOMAINS*DATA_WID   {.., ch1, ch0}; ch0 is in the LSBs
//   dest_in      in   DEST_WID          destination tag, captured at accept
//   flush        in   1                 abort in-flight op (branch_taken_EX)
//   ready        out  1                 1 in IDLE only
//   busy         out  1                 ~ready; pipeline stall request
//   done         out  1                 one-cycle result-valid pulse
//   result       out  NUM_DOMAINS*DATA_WID   per-channel residue; held until next done
//   dest_out     out  DEST_WID          tag of the op that raised done; held with result
// BEHAVIOUR
//   - Reset: state=IDLE, ready=1, busy=0, done=0, result=0, dest_out=0, every accumulator=0.
//     Reset during any state wins over start and flush.
//   - FSM: IDLE -start-> LOAD -> ITER (DATA_WID cycles, bit counter DATA_WID-1..0) -> DONE -> IDLE.
//     With mode=CLRACC: IDLE -> DONE directly.
//   - Accept: start && ready. op1, op2, mode and dest_in are latched, so inputs may change after accept.
//   - LOAD: a = op1 mod m, b = (SQR ? op1 : op2) mod m. Inputs are < 2m, so one conditional
//     subtract suffices. Partial product p = 0.
//   - ITER step k: p = (2p) mod m; if b[k], p = (p + a) mod m. Each step uses one conditional
//     subtract on a DATA_WID+1-bit intermediate and never needs a divider.
//   - DONE: MUL/SQR result = p. MAC: acc = (acc + p) mod m and result = new acc.
//     CLRACC: acc = 0 and result = 0. done=1 for exactly this cycle.
//   - Latency from accept edge to done: MUL/MAC/SQR = DATA_WID+2 cycles; CLRACC = 1 cycle.
//   - start while busy is ignored and not queued. A new start is accepted in the cycle after
//     DONE, so back-to-back throughput is one op per DATA_WID+3 cycles.
//   - flush in LOAD, ITER or DONE returns the FSM to IDLE next cycle. When flushed: no done,
//     result, dest_out and acc are unchanged. flush in IDLE has no effect; flush with start
//     in IDLE means the request is not accepted.
//   - m = 2^DATA_WID (e.g. 256) degenerates to plain wrap-around; the same datapath handles it.
//   - All channels share a single FSM and counter and finish in the same cycle.
// STRUCTURE
//   - Shared package pl_rns_pkg: mode encodings (MODE_MUL/MAC/SQR/CLR), FSM state enum,
//     and the modulus-slice helper function.
//   - Sub-module rns_modmul_lane (one per channel, generate loop): holds a, b, p and acc,
//     with the reduction/step/accumulate datapath.
//   - Top level holds the FSM, bit counter, latched mode/tag, and the output registers.
// TESTING (defaults, MODULI ch1=256 ch0=129)
//   - MUL op1=op2={8'd200,8'd200} -> done at accept+10, result={8'd64,8'd10}, dest_out echoes dest_in.
//   - CLRACC; MAC {3,3}*{5,5}; MAC {4,4}*{4,4} -> results {15,15} then {31,31}.
//     The CLRACC done arrives 1 cycle after accept.
//   - MAC wrap: CLRACC, then MAC {128,128}*{2,2} -> result {8'd0,8'd127}.
//   - flush asserted 3 cycles after accept of MUL -> no done, ready=1 next cycle;
//     a following MAC shows acc unchanged.
//   - start pulsed while busy -> ignored: exactly one done, with the first op's tag and result.
//   - reset asserted mid-ITER -> next cycle ready=1, done=0, result=0, and a subsequent MAC
//     starts from acc=0.

Source files
------------

// File: rtl/pl_rns_pkg.sv
// ----------------------------------------------------------------------------
// pl_rns_pkg
//   Shared definitions for the RNS multi-cycle execute unit:
//     - mode_e  : operation encodings on the 2-bit mode port
//     - state_e : FSM states of the sequencer in pl_ex_rns_mcu
//     - modulus_of() : extracts one channel's modulus from the packed
//                      MODULI parameter vector
// ----------------------------------------------------------------------------
package pl_rns_pkg;

  // Widest packed MODULI vector the helper accepts
  // (NUM_DOMAINS * (DATA_WID+1) must not exceed this).
  localparam int MOD_VEC_MAX = 64;

  typedef enum logic [1:0] {
    MODE_MUL = 2'b00,  // op1 * op2 mod m
    MODE_MAC = 2'b01,  // acc = (acc + op1 * op2) mod m
    MODE_SQR = 2'b10,  // op1 * op1 mod m
    MODE_CLR = 2'b11   // acc = 0
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Channel idx occupies bits [idx*(wid+1) +: wid+1] of the packed vector.
  function automatic int unsigned modulus_of(input logic [MOD_VEC_MAX-1:0] moduli,
                                             input int unsigned          idx,
                                             input int unsigned          wid);
    logic [MOD_VEC_MAX-1:0] shifted;
    shifted = moduli >> (idx * (wid + 1));
    return shifted[31:0] & ((32'd1 << (wid + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/rns_modmul_lane.sv
// ----------------------------------------------------------------------------
// rns_modmul_lane
//   One residue channel of the RNS execute unit: an MSB-first shift-add
//   modular multiplier plus a modular accumulator. Sequencing comes from the
//   shared FSM in the top level; this lane only holds data.
//
//   Ports
//     clk, reset   rising-edge clock, synchronous active-high reset
//     load         reduce op_a/op_b into a/b and clear the partial product
//     step         one shift-add iteration using bit b[bit_idx]
//     bit_idx      multiplier bit consumed by this step (MSB first)
//     acc_upd      acc <= (acc + p) mod m
//     acc_clr      acc <= 0
//     op_a, op_b   raw operands, each < 2m
//     prod         partial product p (final product after the last step)
//     acc_sum      (acc + p) mod m, the value a MAC commits
// ----------------------------------------------------------------------------
module rns_modmul_lane #(
  parameter int          DATA_WID = 8,
  parameter int unsigned MODULUS  = 256,
  localparam int         IDX_W    = (DATA_WID > 1) ? $clog2(DATA_WID) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic [IDX_W-1:0]    bit_idx,
  input  logic                acc_upd,
  input  logic                acc_clr,
  input  logic [DATA_WID-1:0] op_a,
  input  logic [DATA_WID-1:0] op_b,
  output logic [DATA_WID-1:0] prod,
  output logic [DATA_WID-1:0] acc_sum
);

  localparam logic [DATA_WID:0] M = MODULUS[DATA_WID:0];

  // Any x < 2m reduces with a single conditional subtract. When m = 2^DATA_WID
  // the subtract only ever drops the carry bit, i.e. plain wrap-around.
  function automatic logic [DATA_WID-1:0] cond_sub(input logic [DATA_WID:0] x);
    return DATA_WID'((x >= M) ? x - M : x);
  endfunction

  logic [DATA_WID-1:0] a_q, b_q, p_q, acc_q;
  logic [DATA_WID-1:0] red_a, red_b, dbl, stepped, p_next;

  assign red_a   = cond_sub({1'b0, op_a});
  assign red_b   = cond_sub({1'b0, op_b});
  assign dbl     = cond_sub({p_q, 1'b0});
  assign stepped = cond_sub({1'b0, dbl} + {1'b0, a_q});
  assign p_next  = b_q[bit_idx] ? stepped : dbl;
  assign acc_sum = cond_sub({1'b0, acc_q} + {1'b0, p_q});
  assign prod    = p_q;

  // NOTE: these are a handful of flops, not a RAM, so every one of them is
  // reset; a clean start state costs nothing and keeps X out of the results.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      acc_q <= '0;
    end else begin
      if (load) begin
        a_q <= red_a;
        b_q <= red_b;
        p_q <= '0;
      end else if (step) begin
        p_q <= p_next;
      end

      if (acc_clr) begin
        acc_q <= '0;
      end else if (acc_upd) begin
        acc_q <= acc_sum;
      end
    end
  end

endmodule

// File: rtl/pl_ex_rns_mcu.sv
// ----------------------------------------------------------------------------
// pl_ex_rns_mcu
//   Multi-cycle RNS execute unit beside the single-cycle EX ALUs. Runs modular
//   MUL / MAC / SQR / CLRACC on all NUM_DOMAINS residue channels in lock-step
//   under one FSM: IDLE -> LOAD -> ITER (DATA_WID steps) -> DONE -> IDLE,
//   with CLRACC going IDLE -> DONE directly.
//
//   Ports
//     clk, reset   rising-edge clock, synchronous active-high reset
//     start        request, accepted only while ready
//     mode         00 MUL, 01 MAC, 10 SQR, 11 CLRACC
//     op1, op2     packed residues {.., ch1, ch0}, ch0 in the LSBs
//     dest_in      destination tag captured at accept
//     flush        abort the in-flight op (branch taken in EX)
//     ready        high in IDLE only
//     busy         ~ready, stalls IF/ID/EX
//     done         one-cycle result-valid pulse
//     result       per-channel residues, held until the next done
//     dest_out     tag of the op that raised done, held with result
// ----------------------------------------------------------------------------
module pl_ex_rns_mcu
  import pl_rns_pkg::*;
#(
  parameter int                                      NUM_DOMAINS = 2,
  parameter int                                      DATA_WID    = 8,
  parameter logic [NUM_DOMAINS*(DATA_WID+1)-1:0]     MODULI      = {9'd256, 9'd129},
  parameter int                                      DEST_WID    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic [NUM_DOMAINS*DATA_WID-1:0] op1,
  input  logic [NUM_DOMAINS*DATA_WID-1:0] op2,
  input  logic [DEST_WID-1:0]             dest_in,
  input  logic                            flush,
  output logic                            ready,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_DOMAINS*DATA_WID-1:0] result,
  output logic [DEST_WID-1:0]             dest_out
);

  localparam int VEC_W = NUM_DOMAINS * DATA_WID;
  localparam int CNT_W = (DATA_WID > 1) ? $clog2(DATA_WID) : 1;

  state_e              state_q;
  mode_e               mode_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DEST_WID-1:0] dest_q;
  logic [VEC_W-1:0]    op1_q, op2_q;

  logic [VEC_W-1:0]    op_b_sel;
  logic [VEC_W-1:0]    prod_all, acc_sum_all;
  logic [VEC_W-1:0]    res_next;
  logic                lane_load, lane_step, acc_upd, acc_clr;
  logic                commit;

  assign ready = (state_q == ST_IDLE);
  assign busy  = ~ready;

  // A DONE cycle that coincides with flush is discarded: no pulse, no
  // result/tag update, no accumulator write.
  assign commit    = (state_q == ST_DONE) && !flush;
  assign lane_load = (state_q == ST_LOAD);
  assign lane_step = (state_q == ST_ITER);
  assign acc_upd   = commit && (mode_q == MODE_MAC);
  assign acc_clr   = commit && (mode_q == MODE_CLR);
  assign op_b_sel  = (mode_q == MODE_SQR) ? op1_q : op2_q;

  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_lane
    rns_modmul_lane #(
      .DATA_WID (DATA_WID),
      .MODULUS  (modulus_of(MOD_VEC_MAX'(MODULI), i, DATA_WID))
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (lane_load),
      .step    (lane_step),
      .bit_idx (cnt_q),
      .acc_upd (acc_upd),
      .acc_clr (acc_clr),
      .op_a    (op1_q[i*DATA_WID +: DATA_WID]),
      .op_b    (op_b_sel[i*DATA_WID +: DATA_WID]),
      .prod    (prod_all[i*DATA_WID +: DATA_WID]),
      .acc_sum (acc_sum_all[i*DATA_WID +: DATA_WID])
    );
  end

  // NOTE: res_next gets a full default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    res_next = '0;
    case (mode_q)
      MODE_MAC: res_next = acc_sum_all;
      MODE_CLR: res_next = '0;
      default:  res_next = prod_all;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_MUL;
      cnt_q    <= '0;
      dest_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      done     <= 1'b0;
      result   <= '0;
      dest_out <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // flush with start in IDLE squashes the request.
          if (start && !flush) begin
            mode_q  <= mode_e'(mode);
            dest_q  <= dest_in;
            op1_q   <= op1;
            op2_q   <= op2;
            state_q <= (mode_e'(mode) == MODE_CLR) ? ST_DONE : ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= CNT_W'(DATA_WID - 1);
            state_q <= ST_ITER;
          end
        end

        ST_ITER: begin
          // The lanes step on every ITER cycle, including the cnt_q == 0 one.
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          if (commit) begin
            done     <= 1'b1;
            result   <= res_next;
            dest_out <= dest_q;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
